vga_vram_arbiter: RTL and testbench
===================================

// Module: vga_vram_arbiter
// PURPOSE
//  Shares one single-port synchronous pixel RAM between VGA scan-out and a host port.
//  Takes the col/row counts produced by the sync counter and issues display reads at fixed slots.
//  Hands all remaining cycles to host read/write requests.
//  Returns a replicated, pipelined pixel stream aligned to a fixed 3-clock latency.
// PARAMETERS
//  ACTIVE_COLS 640  visible columns per line
//  ACTIVE_ROWS 480  visible rows per frame
//  PIX_SHIFT   3    log2 of pixel replication; each cell is 2^PIX_SHIFT x 2^PIX_SHIFT screen pixels (80x60 cells)
//  ADDR_W      13   RAM address width; must hold CELLS = (ACTIVE_COLS>>PIX_SHIFT)*(ACTIVE_ROWS>>PIX_SHIFT)
//  DATA_W      9    pixel width (3b R, 3b G, 3b B)
// PORTS
//  clk_i         in   1       pixel clock
//  rst_n_i       in   1       asynchronous, active-low reset
//  col_count_i   in   10      column count from sync counter
//  row_count_i   in   10      row count from sync counter
//  host_req_i    in   1       host request; held with addr/we/wdata stable until host_ack_o
//  host_we_i     in   1       1 = write, 0 = read
//  host_addr_i   in   ADDR_W  cell address (row*COLS_C + col)
//  host_wdata_i  in   DATA_W  write data
//  host_ack_o    out  1       one-cycle pulse: request accepted
//  host_rvalid_o out  1       one-cycle pulse: host_rdata_o valid
//  host_rdata_o  out  DATA_W  read data; held until next rvalid
//  ram_addr_o    out  ADDR_W  RAM address (registered)
//  ram_we_o      out  1       RAM write enable (registered)
//  ram_wdata_o   out  DATA_W  RAM write data (registered)
//  ram_rdata_i   in   DATA_W  RAM read data, valid 1 clock after ram_addr_o
//  pixel_o       out  DATA_W  display pixel
// BEHAVIOUR
//  Reset: every output 0; FSM in IDLE; pipelines cleared. Reset mid-transfer abandons it; no ack.
//  Display slot: col<ACTIVE_COLS, row<ACTIVE_ROWS and col[PIX_SHIFT-1:0]==0 (every active cycle if PIX_SHIFT=0).
//  Display address: (row>>PIX_SHIFT)*(ACTIVE_COLS>>PIX_SHIFT) + (col>>PIX_SHIFT), truncated to ADDR_W.
//  Per cycle N, priority is display slot > host_req_i > idle. The slot is decided from counts in N.
//   FSM next state: DISP_RD / HOST_WR / HOST_RD / IDLE, registered at the end of N.
//  DISP_RD: ram_addr_o = display address, ram_we_o = 0 during N+1.
//  HOST_WR: ram_addr_o/ram_wdata_o from host, ram_we_o = 1 during N+1; host_ack_o = 1 during N+1.
//  HOST_RD: ram_we_o = 0, ram_addr_o = host_addr_i during N+1; host_ack_o = 1 during N+1.
//   host_rdata_o is loaded from ram_rdata_i at the end of N+2; host_rvalid_o = 1 during N+3.
//  IDLE: ram_we_o = 0; ram_addr_o holds its last value.
//  Host request and display slot in the same cycle: display wins. Host keeps req; it is served in the next non-display cycle.
//  host_req_i in the cycle where host_ack_o=1 is the same request and must not be re-served.
//   The FSM ignores req for 1 cycle after ack; max host throughput is 1 per 2 clocks.
//  host_addr_i >= CELLS: acked normally, no RAM access (ram_we_o = 0), read returns rdata 0 with rvalid.
//  Display pipeline: active flag and slot flag delayed 3 stages alongside the RAM access.
//   pixel_o (during N+3) = cell fetched for counts in N. Between slots pixel_o holds the last fetched cell (replication).
//   pixel_o = 0 when delayed active flag = 0 (blanking).
//  Latency: pixel_o lags col/row counts by exactly 3 clocks. Sync outputs are delayed 3 clocks outside this block.
//  Counts wrap (col 799->0, row 524->0) need no special handling. The first slot of each line is col 0.
// TESTING
//  1 Reset: assert rst_n_i=0 mid HOST_WR -> all outputs 0 asynchronously; no ack; after release req served once.
//  2 Host write addr 5 data 9'h1AB during blanking (row 500) -> ram_we_o=1, addr 5 next clk; ack 1 cycle.
//  3 Preload cells 0..79 = index; sweep row 0 cols 0..639 -> pixel_o = col>>3 with 3-clk lag; 0 at cols 640..799.
//  4 Host read request at col 0, row 0 (display slot) -> no ack that cycle; ack at col 1.
//     rvalid 2 clks after ack; pixel stream undisturbed.
//  5 Host write addr 4800 (>= CELLS) -> ack, ram_we_o stays 0; host read 4800 -> rvalid with rdata 0.
//  6 Back-to-back host writes with req held -> acks spaced >= 2 clocks; RAM content matches; none lost or duplicated.

Source files
------------

// File: rtl/vga_vram_arbiter_if.sv
// Host access bus for the VGA pixel RAM arbiter: request/ack handshake plus read return.
interface vga_vram_arbiter_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 9
) ();
    logic              host_req_i;
    logic              host_we_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_wdata_i;
    logic              host_ack_o;
    logic              host_rvalid_o;
    logic [DATA_W-1:0] host_rdata_o;

    // Host side drives the request, observes ack and read return.
    modport master (
        output host_req_i, host_we_i, host_addr_i, host_wdata_i,
        input  host_ack_o, host_rvalid_o, host_rdata_o
    );

    // Arbiter side.
    modport slave (
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
        output host_ack_o, host_rvalid_o, host_rdata_o
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Shares a single-port synchronous pixel RAM between VGA scan-out and a host port.
// Display reads take fixed slots; host requests fill the remaining cycles.
// The pixel stream lags the col/row counts by exactly 3 clocks.
module vga_vram_arbiter #(
    parameter int unsigned ACTIVE_COLS = 640,
    parameter int unsigned ACTIVE_ROWS = 480,
    parameter int unsigned PIX_SHIFT   = 3,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 9
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [9:0]        col_count_i,
    input  logic [9:0]        row_count_i,
    vga_vram_arbiter_if.slave host,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [DATA_W-1:0] pixel_o
);
    localparam int unsigned COLS_C = ACTIVE_COLS >> PIX_SHIFT;
    localparam int unsigned ROWS_C = ACTIVE_ROWS >> PIX_SHIFT;
    localparam int unsigned CELLS  = COLS_C * ROWS_C;

    localparam logic [9:0] ACT_COLS_L = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS_L = 10'(ACTIVE_ROWS);
    // Low column bits that must be zero for a fetch slot; zero mask when PIX_SHIFT is 0.
    localparam logic [9:0] SLOT_MASK  = 10'((1 << PIX_SHIFT) - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDispRd,
        StHostWr,
        StHostRd
    } state_e;

    state_e state_q, state_d;

    logic              disp_active;
    logic              disp_slot;
    logic [31:0]       disp_addr_full;
    logic [ADDR_W-1:0] disp_addr;
    logic              host_oob;
    logic              host_busy;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              host_oob_q;
    logic              rd_pend_q;
    logic              rd_oob_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              act1_q, slot1_q, act2_q, slot2_q;
    logic [DATA_W-1:0] pix_q;

    // Decode the display slot and cell address from the current counts.
    always_comb begin
        disp_active    = (col_count_i < ACT_COLS_L) && (row_count_i < ACT_ROWS_L);
        disp_slot      = disp_active && ((col_count_i & SLOT_MASK) == 10'd0);
        disp_addr_full = 32'(row_count_i >> PIX_SHIFT) * COLS_C
                       + 32'(col_count_i >> PIX_SHIFT);
        disp_addr      = disp_addr_full[ADDR_W-1:0];
        host_oob       = 32'(host.host_addr_i) >= CELLS;
        // The ack cycle still sees the same request held high; it must not be served again.
        host_busy      = (state_q == StHostWr) || (state_q == StHostRd);
    end

    // Next state: display slot beats host, host beats idle.
    always_comb begin
        state_d = StIdle;
        if (disp_slot) begin
            state_d = StDispRd;
        end else if (host.host_req_i && !host_busy) begin
            state_d = host.host_we_i ? StHostWr : StHostRd;
        end
    end

    // RAM command for the next cycle; address and data hold when not driven.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        unique case (state_d)
            StDispRd: ram_addr_d = disp_addr;
            StHostWr: begin
                if (!host_oob) begin
                    ram_addr_d  = host.host_addr_i;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = host.host_wdata_i;
                end
            end
            StHostRd: begin
                if (!host_oob) begin
                    ram_addr_d = host.host_addr_i;
                end
            end
            default: ;
        endcase
    end

    // State and registered RAM command.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            host_oob_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            host_oob_q  <= host_oob;
        end
    end

    // Host read return: capture RAM data one cycle after the access, out-of-range reads give 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_pend_q <= 1'b0;
            rd_oob_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rd_pend_q <= (state_q == StHostRd);
            rd_oob_q  <= host_oob_q;
            rvalid_q  <= rd_pend_q;
            if (rd_pend_q) begin
                rdata_q <= rd_oob_q ? '0 : ram_rdata_i;
            end
        end
    end

    // Display pipeline: flags travel alongside the RAM access; pixel holds between slots.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            act1_q  <= 1'b0;
            slot1_q <= 1'b0;
            act2_q  <= 1'b0;
            slot2_q <= 1'b0;
            pix_q   <= '0;
        end else begin
            act1_q  <= disp_active;
            slot1_q <= disp_slot;
            act2_q  <= act1_q;
            slot2_q <= slot1_q;
            if (!act2_q) begin
                pix_q <= '0;
            end else if (slot2_q) begin
                pix_q <= ram_rdata_i;
            end
        end
    end

    assign ram_addr_o         = ram_addr_q;
    assign ram_we_o           = ram_we_q;
    assign ram_wdata_o        = ram_wdata_q;
    assign pixel_o            = pix_q;
    assign host.host_ack_o    = host_busy;
    assign host.host_rvalid_o = rvalid_q;
    assign host.host_rdata_o  = rdata_q;
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural synchronous RAM.
module tb_vga_vram_arbiter;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [9:0]        col;
    logic [9:0]        row;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] pixel;

    logic [DATA_W-1:0] mem [0:8191];
    logic [DATA_W-1:0] exp_arr [0:803];

    int n_checks = 0;
    int n_fail   = 0;

    vga_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) hif ();

    vga_vram_arbiter #(
        .ACTIVE_COLS(640),
        .ACTIVE_ROWS(480),
        .PIX_SHIFT  (3),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .col_count_i(col),
        .row_count_i(row),
        .host       (hif.slave),
        .ram_addr_o (ram_addr),
        .ram_we_o   (ram_we),
        .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata),
        .pixel_o    (pixel)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM; cells beyond the frame return a junk pattern.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr >= 13'd4800) ? 9'h155 : mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bit got_ack = 1'b0;
        hif.host_req_i   = 1'b1;
        hif.host_we_i    = 1'b1;
        hif.host_addr_i  = addr;
        hif.host_wdata_i = data;
        for (int k = 0; k < 16; k++) begin
            step();
            if (hif.host_ack_o) begin
                got_ack = 1'b1;
                break;
            end
        end
        hif.host_req_i = 1'b0;
        check("wr_ack", 32'(got_ack), 32'd1);
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data);
        bit got_ack = 1'b0;
        hif.host_req_i  = 1'b1;
        hif.host_we_i   = 1'b0;
        hif.host_addr_i = addr;
        for (int k = 0; k < 16; k++) begin
            step();
            if (hif.host_ack_o) begin
                got_ack = 1'b1;
                break;
            end
        end
        hif.host_req_i = 1'b0;
        check("rd_ack", 32'(got_ack), 32'd1);
        step();
        check("rd_rvalid_early", 32'(hif.host_rvalid_o), 32'd0);
        step();
        check("rd_rvalid", 32'(hif.host_rvalid_o), 32'd1);
        data = hif.host_rdata_o;
        step();
        check("rd_rvalid_pulse", 32'(hif.host_rvalid_o), 32'd0);
    endtask

    // Sweep row 0 across a full line; optionally issue a host read at the col 0 slot.
    task automatic sweep_row0(input bit with_read);
        for (int i = 0; i < 804; i++) begin
            if (i >= 3) check("pixel", 32'(pixel), 32'(exp_arr[i-3]));
            if (with_read) begin
                if (i == 1) check("slot_no_ack", 32'(hif.host_ack_o), 32'd0);
                if (i == 2) begin
                    check("slot_ack", 32'(hif.host_ack_o), 32'd1);
                    check("slot_rd_addr", 32'(ram_addr), 32'd7);
                    check("slot_rd_we", 32'(ram_we), 32'd0);
                    hif.host_req_i = 1'b0;
                end
                if (i == 3) check("slot_rvalid_early", 32'(hif.host_rvalid_o), 32'd0);
                if (i == 4) begin
                    check("slot_rvalid", 32'(hif.host_rvalid_o), 32'd1);
                    check("slot_rdata", 32'(hif.host_rdata_o), 32'd7);
                end
            end
            if (i < 800) begin
                col = 10'(i);
                row = 10'd0;
            end else begin
                col = 10'd0;
                row = 10'd500;
            end
            exp_arr[i] = (i < 640) ? 9'(i >> 3) : 9'd0;
            if (with_read && i == 0) begin
                hif.host_req_i  = 1'b1;
                hif.host_we_i   = 1'b0;
                hif.host_addr_i = 13'd7;
            end
            step();
        end
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        int n_ack;
        int last_cyc;

        rst_n            = 1'b0;
        col              = 10'd0;
        row              = 10'd500;
        hif.host_req_i   = 1'b0;
        hif.host_we_i    = 1'b0;
        hif.host_addr_i  = '0;
        hif.host_wdata_i = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(hif.host_ack_o), 32'd0);
        check("rst_rvalid", 32'(hif.host_rvalid_o), 32'd0);
        check("rst_rdata", 32'(hif.host_rdata_o), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        rst_n = 1'b1;
        step();

        // Reset mid host write: outputs clear at once, request served once after release.
        hif.host_req_i   = 1'b1;
        hif.host_we_i    = 1'b1;
        hif.host_addr_i  = 13'd100;
        hif.host_wdata_i = 9'h0CC;
        step();
        check("midrst_we_before", 32'(ram_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(ram_we), 32'd0);
        check("midrst_ack", 32'(hif.host_ack_o), 32'd0);
        check("midrst_addr", 32'(ram_addr), 32'd0);
        check("midrst_wdata", 32'(ram_wdata), 32'd0);
        step();
        rst_n = 1'b1;
        n_ack = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (hif.host_ack_o) begin
                n_ack++;
                hif.host_req_i = 1'b0;
            end
        end
        check("postrst_acks", 32'(n_ack), 32'd1);
        check("postrst_mem", 32'(mem[100]), 32'h0CC);
        host_read(13'd100, rd);
        check("postrst_rdata", 32'(rd), 32'h0CC);

        // Single host write during blanking.
        hif.host_req_i   = 1'b1;
        hif.host_we_i    = 1'b1;
        hif.host_addr_i  = 13'd5;
        hif.host_wdata_i = 9'h1AB;
        step();
        check("wr5_we", 32'(ram_we), 32'd1);
        check("wr5_addr", 32'(ram_addr), 32'd5);
        check("wr5_wdata", 32'(ram_wdata), 32'h1AB);
        check("wr5_ack", 32'(hif.host_ack_o), 32'd1);
        hif.host_req_i = 1'b0;
        step();
        check("wr5_ack_pulse", 32'(hif.host_ack_o), 32'd0);
        check("wr5_we_pulse", 32'(ram_we), 32'd0);
        check("wr5_mem", 32'(mem[5]), 32'h1AB);

        // Preload the first cell row with its index, then scan row 0.
        for (int c = 0; c < 80; c++) host_write(13'(c), 9'(c));
        sweep_row0(1'b0);

        // Host read colliding with the col 0 slot; pixel stream checked alongside.
        sweep_row0(1'b1);

        // Out-of-range address: acked, no write, reads back 0.
        hif.host_req_i   = 1'b1;
        hif.host_we_i    = 1'b1;
        hif.host_addr_i  = 13'd4800;
        hif.host_wdata_i = 9'h0F0;
        step();
        check("oob_wr_ack", 32'(hif.host_ack_o), 32'd1);
        check("oob_wr_we", 32'(ram_we), 32'd0);
        hif.host_req_i = 1'b0;
        step();
        check("oob_wr_we_after", 32'(ram_we), 32'd0);
        host_read(13'd4800, rd);
        check("oob_rdata", 32'(rd), 32'd0);

        // Back-to-back writes with request held; new item presented in each ack cycle.
        n_ack    = 0;
        last_cyc = 0;
        hif.host_req_i   = 1'b1;
        hif.host_we_i    = 1'b1;
        hif.host_addr_i  = 13'd200;
        hif.host_wdata_i = 9'h010;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            if (hif.host_ack_o) begin
                if (n_ack > 0) check("b2b_gap", 32'(cyc - last_cyc), 32'd2);
                last_cyc = cyc;
                n_ack++;
                if (n_ack == 4) begin
                    hif.host_req_i = 1'b0;
                    break;
                end
                hif.host_addr_i  = 13'(200 + n_ack);
                hif.host_wdata_i = 9'(16 + n_ack);
            end
        end
        check("b2b_count", 32'(n_ack), 32'd4);
        n_ack = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (hif.host_ack_o) n_ack++;
        end
        check("b2b_no_extra", 32'(n_ack), 32'd0);
        for (int k = 0; k < 4; k++) check("b2b_mem", 32'(mem[200+k]), 32'(16 + k));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
